// File: rtl/image_ram_stream.sv
// image_ram_stream: image RAM with Avalon-MM s1 port and a windowed Avalon-ST streamer; IMAGE_RAM_STRIDE_EN adds a stride input
module image_ram_stream #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18,
  parameter int DEPTH = 262144,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_REQUIRES_DEBUG = 1,
  parameter string INIT_FILE = "image.mif"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                debugaccess,
  output logic [DATA_W-1:0]   readdata,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
`ifdef IMAGE_RAM_STRIDE_EN
  input  logic [ADDR_W-1:0]   stride,
`endif
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop
);
  localparam int NB = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DP = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic ce, s1_in, s1_we;
  logic [DATA_W-1:0] rd1, rd2;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, rd_addr, inc, inc0;
  logic [ADDR_W:0] iss_left, beat_left, len_r;
  logic [DATA_W-1:0] sr_data, d0, d1;
  logic sr_valid, zdone, pop, idle_go, issue, rd_in;
  logic [1:0] cnt, wpos;
  logic [2:0] occ;

  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] s);
    logic [ADDR_W:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    return sum >= DP ? ADDR_W'(sum - DP) : sum[ADDR_W-1:0];
  endfunction

  assign ce = clken & ~reset_req;
  assign s1_in = {1'b0, address} < DP;
  assign s1_we = ce & chipselect & write & (debugaccess | (WRITE_REQUIRES_DEBUG == 0)) & s1_in;
  assign readdata = (READ_LATENCY == 2) ? rd2 : rd1;

  // byte-lane writes from s1; out-of-range addresses never reach the array
  always_ff @(posedge clk) begin
    if (s1_we)
      for (int i = 0; i < NB; i++)
        if (byteenable[i]) mem[address[IW-1:0]][i*8 +: 8] <= writedata[i*8 +: 8];
  end

  // s1 read pipeline, frozen while ce is low; reads old data on a same-address write
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1 <= '0;
      rd2 <= '0;
    end else if (ce) begin
      rd1 <= s1_in ? mem[address[IW-1:0]] : '0;
      rd2 <= rd1;
    end
  end

`ifdef IMAGE_RAM_STRIDE_EN
  logic [ADDR_W-1:0] step_r;
  assign inc0 = ADDR_W'({1'b0, stride} % DP);
  assign inc = step_r;
  // stride is reduced modulo DEPTH once, at launch
  always_ff @(posedge clk) begin
    if (reset) step_r <= '0;
    else if (idle_go) step_r <= inc0;
  end
`else
  assign inc0 = ADDR_W'(1);
  assign inc = ADDR_W'(1);
`endif

  assign pop = st_valid & st_ready;
  assign occ = {1'b0, cnt} - {2'b0, pop} + {2'b0, sr_valid};
  assign idle_go = (state == S_IDLE) & start & (length != '0);
  assign issue = idle_go | ((state == S_RUN) & (iss_left != '0) & (occ < 3'd2));
  assign rd_addr = (state == S_IDLE) ? base_addr : ptr;
  assign rd_in = {1'b0, rd_addr} < DP;
  assign wpos = cnt - {1'b0, pop};
  assign st_valid = cnt != 2'd0;
  assign st_data = d0;
  assign st_sop = st_valid & (beat_left == len_r);
  assign st_eop = st_valid & (beat_left == (ADDR_W + 1)'(1));

  // stream state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end

  // stream next state and status outputs
  always_comb begin
    state_n = state == S_IDLE ? (idle_go ? S_RUN : S_IDLE) :
              state == S_RUN  ? ((pop && beat_left == (ADDR_W + 1)'(1)) ? S_DONE : S_RUN) : S_IDLE;
    busy = state == S_RUN;
    done = (state == S_DONE) | zdone;
  end

  // stream datapath: first read is issued on the start edge, then a 1-cycle RAM read feeds a 2-entry FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      iss_left <= '0;
      beat_left <= '0;
      len_r <= '0;
      sr_valid <= 1'b0;
      sr_data <= '0;
      d0 <= '0;
      d1 <= '0;
      cnt <= 2'd0;
      zdone <= 1'b0;
    end else begin
      zdone <= (state == S_IDLE) & start & (length == '0);
      sr_valid <= issue;
      sr_data <= rd_in ? mem[rd_addr[IW-1:0]] : '0;
      ptr <= idle_go ? adv(base_addr, inc0) : issue ? adv(ptr, inc) : ptr;
      if (idle_go) begin
        len_r <= length;
        beat_left <= length;
        iss_left <= length - 1'b1;
      end else begin
        if (issue) iss_left <= iss_left - 1'b1;
        if (pop) beat_left <= beat_left - 1'b1;
      end
      if (pop) d0 <= d1;
      if (sr_valid) begin
        if (wpos == 2'd0) d0 <= sr_data;
        else d1 <= sr_data;
      end
      cnt <= cnt + {1'b0, sr_valid} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_image_ram_stream.sv
// tb_image_ram_stream: scoreboard bench for image_ram_stream (s1 port and windowed stream, optional IMAGE_RAM_STRIDE_EN)
module tb_image_ram_stream;
  localparam int AW = 18;
  localparam int DEPTH = 1000;
  localparam int WRD = 1;

  logic clk = 0, reset = 1, clken = 0, reset_req = 0, chipselect = 0, write = 0, debugaccess = 0;
  logic start = 0, st_ready = 1;
  logic [AW-1:0] address = '0, base_addr = '0;
  logic [3:0] byteenable = '0;
  logic [31:0] writedata = '0;
  logic [AW:0] length = '0;
`ifdef IMAGE_RAM_STRIDE_EN
  logic [AW-1:0] stride = 1;
`endif
  logic [31:0] readdata, st_data;
  logic busy, done, st_valid, st_sop, st_eop;

  image_ram_stream #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .WRITE_REQUIRES_DEBUG(WRD)) dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .readdata(readdata), .start(start), .base_addr(base_addr),
    .length(length),
`ifdef IMAGE_RAM_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  typedef struct {int due; logic [31:0] v;} rd_t;
  typedef struct {logic [31:0] d; bit sop; bit eop;} beat_t;
  rd_t rdq[$];
  beat_t sbq[$];
  logic [31:0] model [DEPTH];
  logic [31:0] rd_model = '0;
  int rmode = 0, rp = 0, stp = 1, start_cyc = 0, exp_done = -1, nbeats = 0, last_beat = -10;
  bit first_pending = 0, done_seen = 0;
  bit pv = 0, pr = 0, prst = 0, ps = 0, pe = 0;
  logic [31:0] pd = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // s1 access with the reference memory updated after the read (old data on collision)
  task automatic s1(input bit ck, input bit rr, input bit cs, input bit wr, input bit dbg,
                    input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd, input bit chk);
    int ai = int'(a);
    clken = ck; reset_req = rr; chipselect = cs; write = wr; debugaccess = dbg;
    address = a; byteenable = be; writedata = wd;
    if (ck && !rr) begin
      rd_model = (ai < DEPTH) ? model[ai] : 32'h0;
      if (cs && wr && (dbg || WRD == 0) && ai < DEPTH)
        for (int i = 0; i < 4; i++) if (be[i]) model[ai][8*i +: 8] = wd[8*i +: 8];
    end
    if (chk) rdq.push_back('{cyc + 1, rd_model});
    step();
  endtask

  task automatic s1_idle();
    clken = 0; chipselect = 0; write = 0; reset_req = 0;
  endtask

  // drive a start pulse and queue the window the reference memory predicts
  task automatic launch(input int base, input int len);
    int p = base;
    for (int i = 0; i < len; i++) begin
      sbq.push_back('{(p < DEPTH) ? model[p] : 32'h0, i == 0, i == len - 1});
      p = (p + stp) % DEPTH;
    end
`ifdef IMAGE_RAM_STRIDE_EN
    stride = AW'(stp);
`endif
    start = 1; base_addr = AW'(base); length = (AW + 1)'(len);
    start_cyc = cyc; first_pending = len != 0; done_seen = 0;
    if (len == 0) exp_done = cyc + 1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done_seen; i++) step();
    check("done_timeout", 32'(done_seen), 1);
    step();
    check("busy_after_done", 32'(busy), 0);
  endtask

  always @(posedge clk) begin
    #1;
    st_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (rp % 4 == 0 || rp % 4 == 3) : 1'($urandom % 2);
    rp++;
  end

  // monitor: s1 readdata, done timing, stream beats against the scoreboard
  always @(negedge clk) begin
    rd_t r;
    beat_t b;
    if (rdq.size() != 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      check("readdata", readdata, r.v);
    end
    check("done_pulse", 32'(done), 32'(cyc == exp_done));
    if (done) done_seen = 1;
    if (first_pending && st_valid) begin
      check("first_valid_latency", cyc, start_cyc + 2);
      first_pending = 0;
    end
    if (pv && !pr && !prst) begin
      check("stall_valid", 32'(st_valid), 1);
      check("stall_data", st_data, pd);
      check("stall_sop_eop", {st_sop, st_eop}, {ps, pe});
    end
    if (st_valid && st_ready) begin
      if (sbq.size() == 0) check("extra_beat", 32'(st_valid), 0);
      else begin
        b = sbq.pop_front();
        check("beat_data", st_data, b.d);
        check("beat_sop_eop", {st_sop, st_eop}, {b.sop, b.eop});
        if (rmode == 0 && !b.sop) check("throughput", cyc, last_beat + 1);
        last_beat = cyc;
        nbeats++;
        if (b.eop) exp_done = cyc + 1;
      end
    end
    pv = st_valid; pr = st_ready; pd = st_data; ps = st_sop; pe = st_eop; prst = reset;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (3) step();
    check("rst_readdata", readdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_st_valid", 32'(st_valid), 0);
    check("rst_sop_eop", {st_sop, st_eop}, 0);
    check("rst_st_data", st_data, 0);
    reset = 0;
    for (int i = 0; i < DEPTH; i++) s1(1, 0, 1, 1, 1, AW'(i), 4'hF, i < 8 ? 32'(i) : $urandom, 0);
    s1(1, 0, 0, 0, 0, AW'(3), 4'h0, 0, 1);
    s1(1, 0, 1, 1, 1, AW'('h10), 4'hF, 32'h0, 1);
    s1(1, 0, 1, 1, 1, AW'('h10), 4'b0101, 32'hA5A5_5A5A, 1);
    s1(1, 0, 0, 0, 0, AW'('h10), 4'h0, 0, 1);
    check("byte_lanes_literal", readdata, 32'h00A5_005A);
    s1(1, 0, 1, 1, 0, AW'('h10), 4'hF, 32'hFFFF_FFFF, 1);
    s1(1, 0, 0, 0, 0, AW'('h10), 4'h0, 0, 1);
    s1(1, 0, 0, 0, 0, AW'(5), 4'h0, 0, 1);
    s1(1, 1, 1, 1, 1, AW'('h10), 4'hF, 32'h1234_5678, 1);
    s1(0, 0, 1, 1, 1, AW'('h10), 4'hF, 32'h1234_5678, 1);
    s1(1, 0, 0, 0, 0, AW'('h10), 4'h0, 0, 1);
    s1(1, 0, 0, 0, 0, AW'(DEPTH + 3), 4'h0, 0, 1);
    repeat (300)
      s1($urandom % 4 != 0, $urandom % 10 == 0, $urandom % 2, $urandom % 2, $urandom % 4 != 0,
         $urandom % 10 == 0 ? AW'($urandom_range(DEPTH, DEPTH + 50)) : AW'($urandom_range(0, DEPTH - 1)),
         4'($urandom), $urandom, 1);
    s1_idle();
    step();
    rmode = 0; launch(2, 4); step(); start = 0;
    check("busy_running", 32'(busy), 1);
    wait_done();
    rmode = 1; launch(2, 4); step();
    base_addr = AW'(100); length = 3; step(); start = 0;
    wait_done();
    rmode = 0; launch(DEPTH - 2, 4); step(); start = 0;
    wait_done();
    launch(5, 0); step(); start = 0;
    repeat (3) begin
      check("zero_len_no_valid", 32'(st_valid), 0);
      step();
    end
    rmode = 0; n0 = nbeats; launch(10, 6); step(); start = 0;
    for (int i = 0; i < 50 && nbeats < n0 + 2; i++) step();
    reset = 1; step(); reset = 0;
    check("midrst_valid", 32'(st_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    sbq.delete(); exp_done = -1; first_pending = 0; rd_model = '0;
    repeat (5) step();
    launch(0, 5); step(); start = 0;
    wait_done();
    launch(20, 1);
    s1(1, 0, 1, 1, 1, AW'(20), 4'hF, 32'hDEAD_BEEF, 1);
    start = 0; s1_idle();
    wait_done();
    launch(20, 1); step(); start = 0;
    wait_done();
    repeat (10) begin
      rmode = $urandom_range(0, 2);
`ifdef IMAGE_RAM_STRIDE_EN
      stp = $urandom_range(0, 5);
`endif
      launch($urandom_range(0, DEPTH - 1), $urandom_range(1, 12)); step(); start = 0;
      wait_done();
    end
    check("scoreboard_empty", sbq.size(), 0);
    check("read_queue_empty", rdq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/image_ram_stream.md
Name: image_ram_stream

Overview:
- Parametrised on-chip image memory with an Avalon-MM slave port (s1) for CPU and debugger access.
- Adds an internal second read port driving an Avalon-ST source, which streams a programmable window of words to downstream video/processing logic.
- Sits between the Nios data master and the image pipeline, replacing fixed-size single-port image RAMs.

Parameters:
- DATA_W, 32, word width; multiple of 8. Byte lanes NB = DATA_W/8.
- ADDR_W, 18, word address width.
- DEPTH, 262144, number of words; must be <= 2**ADDR_W.
- READ_LATENCY, 1, s1 read latency in cycles; legal values 1 or 2.
- WRITE_REQUIRES_DEBUG, 1, 1 = s1 writes allowed only with debugaccess high (ROM behaviour); 0 = always writable.
- INIT_FILE, "image.mif", memory initialisation file.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  s1 clock enable.
- reset_req  in  1  s1 hold request; effective enable is ce = clken & ~reset_req.
- address  in  ADDR_W  s1 word address.
- byteenable  in  NB  s1 byte lanes.
- chipselect  in  1  s1 select.
- write  in  1  s1 write strobe.
- writedata  in  DATA_W  s1 write data.
- debugaccess  in  1  s1 debugger access qualifier.
- readdata  out  DATA_W  s1 read data.
- start  in  1  one-cycle pulse that launches a stream.
- base_addr  in  ADDR_W  first stream word; sampled on start.
- length  in  ADDR_W+1  number of words to stream; sampled on start.
- busy  out  1  stream in progress.
- done  out  1  one-cycle completion pulse.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream beat valid.
- st_ready  in  1  downstream ready.
- st_sop  out  1  first beat of window.
- st_eop  out  1  last beat of window.

Behaviour:
- Reset values: readdata=0, busy=0, done=0, st_valid=0, st_sop=0, st_eop=0, st_data=0. Memory contents are not cleared by reset.
- s1 write: takes effect at the clock edge when ce & chipselect & write & (debugaccess | ~WRITE_REQUIRES_DEBUG). Only lanes with byteenable[i]=1 are updated.
- s1 read:
  - readdata shows mem[address] READ_LATENCY cycles after address is presented with ce=1.
  - Read-during-write on the same s1 address returns old data.
  - With ce=0, readdata holds its value and writes are ignored.
- Addresses >= DEPTH: writes are dropped; reads return 0.
- Stream port: independent of ce. Its read path has a fixed 1-cycle RAM latency into a 2-entry output FIFO.
- Stream FSM:
  - IDLE: start with length>0 latches ptr=base_addr and remaining=length, then goes to RUN with busy=1. start with length=0 pulses done on the next cycle and stays in IDLE.
  - RUN:
    - Issues a RAM read when FIFO occupancy + in-flight reads < 2 and issued < length.
    - ptr increments per issued read and wraps from DEPTH-1 to 0.
    - A beat transfers when st_valid & st_ready.
    - Goes to DONE when the last beat transfers.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Stream beat rules:
  - st_sop is high on the first beat only; st_eop is high on the last beat only. A length=1 stream has both high.
  - st_data and st_valid hold stable while st_valid & ~st_ready.
  - Throughput is 1 beat/clock under continuous st_ready. First st_valid appears 2 cycles after start.
- start while busy is ignored.
- Port conflict: an s1 write and a stream read to the same address in the same cycle → the stream gets old data.
- Reset mid-stream: FSM goes to IDLE, FIFO is flushed, st_valid drops on the next edge, and no done pulse is generated.

Optional Feature:
- Macro: IMAGE_RAM_STRIDE_EN.
- Defined: adds input stride [ADDR_W-1:0], sampled on start. ptr advances by stride per issued read, modulo DEPTH. stride=0 repeats the base word length times.
- Undefined: no stride port; the increment is fixed at 1.

Test Plan:
- s1 write 0xA5A5_5A5A to addr 0x10 with byteenable=4'b0101, debugaccess=1 (after a full-word write of 0) → s1 read of 0x10 returns 0x00A5_005A after READ_LATENCY cycles.
- WRITE_REQUIRES_DEBUG=1, s1 write with debugaccess=0 → contents unchanged. Same write with reset_req=1 → ignored and readdata held.
- Preload words 0..7 = index; start with base=2, length=4, st_ready=1 → beats 2,3,4,5 on consecutive cycles; sop on 2, eop on 5; done one cycle after last beat.
- Same stream with st_ready toggled 1,0,0,1,… → no lost or duplicated beats, data stable while stalled, order 2,3,4,5.
- base=DEPTH-2, length=4 → beats mem[DEPTH-2], mem[DEPTH-1], mem[0], mem[1]. start with length=0 → done pulse only, no st_valid.
- reset asserted after 2 of 6 beats → st_valid=0 and busy=0 next cycle, no done. A new start afterwards streams correctly.
